// File: rtl/reqmem.sv
// On-chip memory target for the CPU bus request port: single and line-burst
// reads/writes against an inferred block RAM with big-endian byte masks.
module reqmem #(
  parameter int          AW   = 12,
  parameter logic [15:0] BASE = 16'h0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_len,
  input  logic [3:0]  req_mask,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic        write_valid,
  input  logic [31:0] write_data,
  output logic        read_valid,
  output logic [31:0] read_data,
  input  logic        read_ack
);

  typedef enum logic [1:0] {IDLE, WR, RD_ADDR, RD_DATA} state_t;

  state_t         state;
  logic [2:0]     cnt;
  logic [AW-1:0]  widx;
  logic [AW-1:0]  widx_next;
  logic [3:0]     mask;
  logic           hit;
  logic           wr_en;
  logic [31:0]    ram_q;
  logic [31:0]    mem [2**AW];
  logic           unused_addr;

  // Bursts wrap inside the aligned 4-word line.
  assign widx_next   = {widx[AW-1:2], widx[1:0] + 2'd1};
  assign wr_en       = (state == WR) && write_valid && hit;
  assign unused_addr = ^req_addr[15:0];

  // Block RAM with per-byte enables; mask bit 3 covers data[31:24].
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (mask[b]) mem[widx][8*b +: 8] <= write_data[8*b +: 8];
      end
    end
    ram_q <= mem[widx];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      req_ready  <= 1'b0;
      read_valid <= 1'b0;
      read_data  <= '0;
      cnt        <= '0;
      widx       <= '0;
      mask       <= '0;
      hit        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!req_ready) begin
            req_ready <= 1'b1;
          end else if (req_valid) begin
            cnt       <= (req_len == 3'd0) ? 3'd1 : req_len;
            widx      <= req_addr[AW+1:2];
            mask      <= req_mask;
            hit       <= (req_addr[31:16] == BASE);
            req_ready <= 1'b0;
            state     <= req_we ? WR : RD_ADDR;
          end
        end
        WR: begin
          if (write_valid) begin
            widx <= widx_next;
            cnt  <= cnt - 3'd1;
            if (cnt == 3'd1) begin
              state     <= IDLE;
              req_ready <= 1'b1;
            end
          end
        end
        RD_ADDR: begin
          state <= RD_DATA;
        end
        RD_DATA: begin
          // First cycle here captures the registered RAM word; then hold for ack.
          if (!read_valid) begin
            read_data  <= hit ? ram_q : 32'hFFFF_FFFF;
            read_valid <= 1'b1;
          end else if (read_ack) begin
            read_valid <= 1'b0;
            widx       <= widx_next;
            cnt        <= cnt - 3'd1;
            if (cnt == 3'd1) begin
              state     <= IDLE;
              req_ready <= 1'b1;
            end else begin
              state <= RD_ADDR;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/reqmem.md
# reqmem

On-chip memory target at the far end of the CPU bus interface's internal request port. It accepts single and line-burst (4-beat) read/write requests and services them from an internal inferred block RAM. On writes it applies big-endian byte masks. On reads it presents data on a valid/ack handshake. It owns `req_ready`, `read_valid` and `read_data`, and consumes `write_valid`, `write_data` and `read_ack`.

## Interface
- `AW`, 12: RAM word-address width (2^AW × 32-bit words); legal range 8..14.
- `BASE`, 16'h0000: value matched against `req_addr[31:16]` for a hit.

- `clk_i`  in  1  system clock; the only clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  request present; held until accepted.
- `req_ready`  out  1  target can accept a request.
- `req_len`  in  3  beat count; 1 = single, 4 = line; 0 is treated as 1.
- `req_mask`  in  4  byte enables; bit3 = `data[31:24]` (byte offset 0).
- `req_addr`  in  32  byte address.
- `req_we`  in  1  1 = write, 0 = read.
- `write_valid`  in  1  one-cycle pulse per write beat.
- `write_data`  in  32  write beat data, valid with `write_valid`.
- `read_valid`  out  1  read beat data available.
- `read_data`  out  32  read beat data.
- `read_ack`  in  1  one-cycle pulse; consumes the current read beat.

## Operation
- States: IDLE, WR, RD_ADDR, RD_DATA.
- IDLE: `req_ready`=1. On a rising edge with `req_valid & req_ready`, the block latches:
  - `cnt` = `req_len` (0→1);
  - `widx` = `req_addr[AW+1:2]`;
  - `mask`, `we`;
  - `hit` = (`req_addr[31:16]` == `BASE`).
  
  At the same edge `req_ready` goes to 0, and the next state is WR if `we`, otherwise RD_ADDR.
- WR: each `write_valid` pulse writes `write_data` to RAM[`widx`] under `mask`; unmasked bytes are unchanged.
  - If `hit`=0 the write is discarded.
  - Each pulse increments `widx[1:0]` mod 4, keeping the upper bits (line wrap), and decrements `cnt`.
  - Pulse with `cnt`==1 → IDLE, `req_ready`=1 at the same edge.
- RD_ADDR: the RAM address is `widx`. Next state is RD_DATA; RAM output is registered into `read_data`.
  - If `hit`=0, `read_data` = 32'hFFFF_FFFF.
- RD_DATA: `read_valid`=1 and `read_data` is held stable until `read_ack`. On `read_ack`:
  - `read_valid` → 0 at the same edge;
  - `widx[1:0]` += 1 mod 4, `cnt` -= 1;
  - if `cnt` was 1, → IDLE (`req_ready`=1); otherwise → RD_ADDR.
- The read mask is ignored; the full word is always returned.
- Stray `write_valid` outside WR and stray `read_ack` outside RD_DATA are ignored: no RAM change and no state change.
- `req_valid` while `req_ready`=0 is not accepted; the requester holds it.
- RAM contents are not reset and are undefined at power-up.

## Timing
- Reset (`rst_ni`=0, asynchronous) forces:
  - state=IDLE, `req_ready`=0, `read_valid`=0, `read_data`=0, `cnt`=0;
  - this applies mid-burst too: a partial write burst keeps the beats already written, and a pending read beat is dropped.
- `req_ready` rises at the first rising `clk_i` edge after `rst_ni` deasserts.
- Accept edge T. For a read, `read_valid`=1 after edge T+2.
- After `read_ack` at edge A, the next beat has `read_valid`=1 after edge A+2. `read_valid` is never high for two consecutive beats without a low cycle in between.
- A write beat on `write_valid` at edge W is visible to a read whose RD_ADDR cycle is after W.
- `write_valid` may arrive as early as the cycle after T; beats may be back-to-back.
- After the last beat completes at edge E (final write pulse or final `read_ack`), `req_ready`=1 after E, and a new request can be accepted at E+1.
- All outputs are registered; there are no combinational input→output paths.

## Test plan
- **Reset**: hold `rst_ni`=0 → `req_ready`=0, `read_valid`=0, `read_data`=0. Release → `req_ready`=1 after one edge. Assert `rst_ni`=0 mid-RD_DATA → `read_valid` drops immediately (asynchronously).
- **Single write, masked read-back**:
  - Write `addr`=0x0000_0010, `mask`=4'b1111, data 0x11223344; then write `mask`=4'b0100, data 0xAABBCCDD to the same address.
  - Read `len`=1 → `read_data`=0x11BB3344, with `read_valid` 2 cycles after accept.
- **Line burst with wrap**:
  - Write `len`=4 at `addr`=0x0000_0028 with data 1, 2, 3, 4.
  - Reads return 1, 2, 3, 4 as follows: words 0x28=1, 0x2C=2, 0x20=3, 0x24=4.
  - Burst read `len`=4 at 0x20 → 3, 4, 1, 2, each beat held until `read_ack`.
- **Miss**:
  - With `BASE`=16'h0000, read `addr`=0x4000_0000 → 0xFFFF_FFFF.
  - Write 0xDEADBEEF there, then read `addr`=0x0000_0000 → unchanged.
- **Backpressure and strays**:
  - Delay `read_ack` by 20 cycles → `read_data` stable throughout.
  - Stray `write_valid` in IDLE and stray `read_ack` in RD_ADDR → no RAM or state change.
  - `req_valid` held during a burst → accepted exactly one cycle after `req_ready` rises.
- **Length 0**: write `len`=0 → exactly one beat consumed, then IDLE.
